// File: rtl/oh_rstgen_pkg.sv
// Shared types and sizing helpers for the oh_rstgen reset sequencer.
// Provides the FSM state encoding and the timer/index width functions.
package oh_rstgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oh_rstgen_timer.sv
// Loadable down-counter that saturates at zero, with terminal-count flag.
// Ports: clk, nrst_in (async low), load, load_val[W-1:0], tc.
module oh_rstgen_timer
    import oh_rstgen_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         nrst_in,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/oh_rstgen.sv
// Reset generator: synchronizes nrst_in, holds, then releases N resets.
// Ports: clk, nrst_in, sw_rst in; nrst_out[N-1:0], busy, done out.
module oh_rstgen
    import oh_rstgen_pkg::*;
#(
    parameter int PS   = 2,
    parameter int N    = 4,
    parameter int HOLD = 16,
    parameter int GAP  = 4
) (
    input  logic         clk,
    input  logic         nrst_in,
    input  logic         sw_rst,
    output logic [N-1:0] nrst_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(HOLD, GAP);
    localparam int IW = idx_width(N);

    logic [PS-1:0] sync;
    logic          rst_ok;
    logic          rst_rise;
    state_t        state;
    logic [IW-1:0] idx;
    logic          last;
    logic          t_load;
    logic [CW-1:0] t_val;
    logic          tc;

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            sync <= '0;
        end else begin
            sync <= {sync[PS-2:0], 1'b1};
        end
    end

    assign rst_ok = sync[PS-1];
    // HOLD is entered on the same edge that rst_ok rises, so the
    // FSM looks at the value being shifted into the last stage.
    assign rst_rise = sync[PS-2] | rst_ok;
    assign last = (idx == IW'(N - 1));

    always_comb begin
        t_load = 1'b0;
        t_val  = CW'(HOLD - 1);
        if (state == ST_IDLE) begin
            t_load = rst_rise;
        end else if (sw_rst) begin
            t_load = 1'b1;
        end else if (tc && (state == ST_HOLD ||
                            (state == ST_RELEASE && !last))) begin
            t_load = 1'b1;
            t_val  = CW'(GAP - 1);
        end
    end

    oh_rstgen_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .nrst_in  (nrst_in),
        .load     (t_load),
        .load_val (t_val),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge nrst_in) begin
        if (!nrst_in) begin
            state    <= ST_IDLE;
            nrst_out <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            idx      <= '0;
        end else if (state == ST_IDLE) begin
            if (rst_rise) begin
                state <= ST_HOLD;
            end
        end else if (sw_rst) begin
            state    <= ST_HOLD;
            nrst_out <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            idx      <= '0;
        end else begin
            unique case (state)
                ST_HOLD: begin
                    if (tc) begin
                        nrst_out[0] <= 1'b1;
                        if (N == 1) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= IW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (tc) begin
                        nrst_out[idx] <= 1'b1;
                        if (last) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oh_rstgen.sv
// Directed bench for oh_rstgen (PS=2, N=4, HOLD=16, GAP=4).
// Expected outputs come from a release-timing model via a scoreboard.
module tb_oh_rstgen;

    localparam int PS   = 2;
    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic         clk = 1'b0;
    logic         nrst_in;
    logic         sw_rst;
    logic [N-1:0] nrst_out;
    logic         busy;
    logic         done;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_no = 0;
    bit   active = 0;
    int   hi = 0;
    int   d = 0;
    string phase = "init";

    oh_rstgen #(.PS(PS), .N(N), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk      (clk),
        .nrst_in  (nrst_in),
        .sw_rst   (sw_rst),
        .nrst_out (nrst_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Bit k is released HOLD + k*GAP edges after the reset event edge.
    function automatic logic [5:0] model_exp();
        logic [3:0] b;
        logic       dn;
        b = '0;
        for (int k = 0; k < N; k++) begin
            if (active && d >= HOLD + k * GAP) b[k] = 1'b1;
        end
        dn = &b;
        return {b, ~dn, dn};
    endfunction

    task automatic compare_head();
        exp_t e;
        logic [5:0] obs;
        e   = q.pop_front();
        obs = {nrst_out, busy, done};
        n_cmp++;
        assert (obs === e.v) else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%b expected=%b",
                   e.tag, edge_no, obs, e.v);
        end
    endtask

    task automatic tick();
        exp_t e;
        if (!nrst_in) begin
            active = 0;
            hi = 0;
        end else if (!active) begin
            hi++;
            if (hi >= PS) begin
                active = 1;
                d = 0;
            end
        end else if (sw_rst) begin
            d = 0;
        end else begin
            d++;
        end
        e.tag = phase;
        e.v   = model_exp();
        q.push_back(e);
        @(posedge clk);
        edge_no++;
        #1;
        compare_head();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_now();
        exp_t e;
        e.tag = phase;
        e.v   = model_exp();
        q.push_back(e);
        compare_head();
    endtask

    task automatic async_drop();
        #2;
        nrst_in = 1'b0;
        active = 0;
        hi = 0;
        #1;
        check_now();
    endtask

    initial begin
        nrst_in = 1'b1;
        sw_rst  = 1'b0;
        #1;
        nrst_in = 1'b0;
        #1;
        phase = "reset_state";
        check_now();

        phase = "idle_sw_ignored";
        sw_rst = 1'b1;
        ticks(3);
        sw_rst = 1'b0;

        phase = "powerup";
        edge_no = 0;
        nrst_in = 1'b1;
        ticks(34);

        phase = "sw_pulse_run";
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        ticks(32);

        phase = "sw_in_release";
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        ticks(21);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        ticks(32);

        phase = "sw_held5";
        sw_rst = 1'b1;
        ticks(5);
        sw_rst = 1'b0;
        ticks(32);

        phase = "sw_at_expiry";
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        ticks(15);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        ticks(32);

        phase = "async_mid_release";
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        ticks(22);
        async_drop();
        phase = "async_held";
        ticks(2);

        phase = "rerelease";
        nrst_in = 1'b1;
        ticks(34);

        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_drain left=%0d required=0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/oh_rstgen.md
OH_RSTGEN -- requirements
Module: oh_rstgen

Interface
REQ-001 SHALL have parameter PS, default 2: number of reset synchronizer stages, minimum 2.
REQ-002 SHALL have parameter N, default 4: number of sequenced reset outputs, minimum 1.
REQ-003 SHALL have parameter HOLD, default 16: minimum reset assertion length in clk cycles, minimum 1.
REQ-004 SHALL have parameter GAP, default 4: clk cycles between successive output releases, minimum 1.
REQ-005 SHALL have port clk, input, 1: clock.
REQ-006 SHALL have port nrst_in, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port sw_rst, input, 1: synchronous software reset request, sampled each rising clk edge.
REQ-008 SHALL have port nrst_out, output, N: sequenced active-low resets; bit 0 released first.
REQ-009 SHALL have port busy, output, 1: high while any nrst_out bit is low.
REQ-010 SHALL have port done, output, 1: high when all nrst_out bits are high; always equal to !busy.

Function
REQ-011 SHALL pass nrst_in through an internal PS-stage synchronizer: async clear to 0, shift in 1 each edge; its last stage is rst_ok.
REQ-012 SHALL implement FSM states IDLE (rst_ok low), HOLD, RELEASE, RUN.
REQ-013 SHALL stay in IDLE with all nrst_out low while rst_ok is low.
REQ-014 SHALL transition IDLE->HOLD on the first edge with rst_ok high and load the cycle counter; that edge counts as edge E.
REQ-015 SHALL transition HOLD->RELEASE and drive nrst_out[0] high after edge E+HOLD.
REQ-016 SHALL drive nrst_out[k] high after edge E+HOLD+k*GAP for k = 1..N-1; once released, bits stay high until the next reset event.
REQ-017 SHALL transition RELEASE->RUN on the edge that releases nrst_out[N-1], with done rising on the same edge; when N=1, HOLD goes directly to RUN.
REQ-018 SHALL treat sw_rst high sampled at edge E in HOLD, RELEASE or RUN as a reset event: all nrst_out low after E, state HOLD, counter reloaded; release timing per REQ-015/016 relative to this E.
REQ-019 SHALL give sw_rst priority over counter expiry or a release step on the same edge.
REQ-020 SHALL ignore sw_rst in IDLE.
REQ-021 SHALL restart HOLD from zero if sw_rst is held high for multiple cycles; release begins HOLD edges after the last high sample.
REQ-022 SHALL size the counter to ceil(log2(max(HOLD,GAP)+1)) bits and keep it from wrapping; it saturates or reloads at each phase boundary.
REQ-023 SHALL drive nrst_out only from flops, with no combinational path from sw_rst to nrst_out.

Reset
REQ-024 SHALL, on nrst_in low, immediately and asynchronously clear the synchronizer, all nrst_out, done, and set busy high and the state to IDLE, even mid-HOLD or mid-RELEASE.
REQ-025 SHALL perform all deassertion only synchronously to clk, through the synchronizer and the FSM.
REQ-026 SHALL have reset values nrst_out = 0, busy = 1, done = 0, state = IDLE, counter = 0.

Structure
REQ-027 SHALL place the FSM state encoding (IDLE, HOLD, RELEASE, RUN) and the counter-width function in the shared package oh_rstgen_pkg.
REQ-028 SHALL implement the synchronizer inline and SHALL split out one sub-module, oh_rstgen_timer, containing the loadable down-counter with a terminal-count flag.
REQ-029 SHALL keep the per-output release index (ceil(log2(N)) bits) in the top level.

Verification (PS=2, N=4, HOLD=16, GAP=4)
REQ-030 SHALL verify power-up: nrst_in low then high before edge 1 -> nrst_out=0000 through edge 17; nrst_out[0] high after edge 18, [1] after 22, [2] after 26, [3] after 30; done rises after edge 30.
REQ-031 SHALL verify sw_rst pulse in RUN at edge E -> nrst_out=0000 and busy=1 after E; bit0 high after E+16, bit3 and done high after E+28.
REQ-032 SHALL verify sw_rst in RELEASE when nrst_out=0011 -> 0000 after the sampling edge; full sequence restarts with HOLD=16.
REQ-033 SHALL verify sw_rst held high for 5 cycles -> bit0 releases 16 edges after the last high sample.
REQ-034 SHALL verify nrst_in low mid-RELEASE between edges -> nrst_out=0000 and busy=1 with no clk edge required; on re-release, timing matches REQ-030.
REQ-035 SHALL verify sw_rst on the edge where HOLD expires -> no release; HOLD restarts.
